// File: rtl/sfifo_ext_pkg.sv
// Shared types and helpers for the sfifo_ext single-clock FIFO.
// Status flags live here so every FIFO variant derives them the same way.
package sfifo_ext_pkg;

    typedef struct packed {
        logic wfull;
        logic afull;
        logic rempty;
        logic aempty;
    } flags_t;

    function automatic flags_t calc_flags(input int level, input int depth,
                                          input int afull_lvl, input int aempty_lvl);
        flags_t f;
        f.wfull  = (level == depth);
        f.afull  = (level >= afull_lvl);
        f.rempty = (level == 0);
        f.aempty = (level <= aempty_lvl);
        return f;
    endfunction

endpackage

// File: rtl/sfifo_ext_ram.sv
// Register-array storage for sfifo_ext: one write port, asynchronous read, no reset.
module sfifo_ext_ram #(
    parameter int abits = 3,
    parameter int dbits = 32
) (
    input  logic             i_clk,
    input  logic             we,
    input  logic [abits-1:0] waddr,
    input  logic [dbits-1:0] wdata,
    input  logic [abits-1:0] raddr,
    output logic [dbits-1:0] rdata
);

    logic [dbits-1:0] mem [1 << abits];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_ext.sv
// Single-clock FIFO with registered or first-word-fall-through read, fill level and thresholds.
// Optional sticky overflow/underflow flags are built when SFIFO_EXT_ERR_EN is defined.
module sfifo_ext
    import sfifo_ext_pkg::*;
#(
    parameter int abits      = 3,
    parameter int dbits      = 32,
    parameter int fwft       = 0,
    parameter int afull_lvl  = (1 << abits) - 1,
    parameter int aempty_lvl = 1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
`ifdef SFIFO_EXT_ERR_EN
    input  logic             i_err_clr,
    output logic             o_ovf,
    output logic             o_udf,
`endif
    input  logic             i_wr,
    input  logic [dbits-1:0] i_wdata,
    output logic             o_wfull,
    output logic             o_afull,
    input  logic             i_rd,
    output logic [dbits-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_rempty,
    output logic             o_aempty,
    output logic [abits:0]   o_level
);

    localparam int DEPTH = 1 << abits;
    localparam int PW    = abits + 1;

    typedef struct packed {
        logic [abits:0]   wptr;
        logic [abits:0]   rptr;
        logic [abits:0]   level;
        flags_t           flags;
        logic [dbits-1:0] rdata;
        logic             rvalid;
    } regs_t;

    localparam regs_t REGS_RST = '{
        wptr:   '0,
        rptr:   '0,
        level:  '0,
        flags:  calc_flags(0, DEPTH, afull_lvl, aempty_lvl),
        rdata:  '0,
        rvalid: 1'b0
    };

    regs_t            r;
    logic             we;
    logic             re;
    logic [abits:0]   level_next;
    logic [dbits-1:0] ram_rdata;

    // Full and empty are never bypassed, even when the opposite side is active.
    assign we         = i_wr & ~r.flags.wfull;
    assign re         = i_rd & ~r.flags.rempty;
    assign level_next = r.level + PW'(we) - PW'(re);

    sfifo_ext_ram #(
        .abits (abits),
        .dbits (dbits)
    ) u_ram (
        .i_clk (i_clk),
        .we    (we),
        .waddr (r.wptr[abits-1:0]),
        .wdata (i_wdata),
        .raddr (r.rptr[abits-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r <= REGS_RST;
        end else begin
            r.wptr  <= r.wptr + PW'(we);
            r.rptr  <= r.rptr + PW'(re);
            r.level <= level_next;
            r.flags <= calc_flags(int'(level_next), DEPTH, afull_lvl, aempty_lvl);
            r.rvalid <= re;
            if (re) begin
                r.rdata <= ram_rdata;
            end
        end
    end

    // In FWFT mode the head entry is presented straight from the array.
    assign o_rdata  = (fwft != 0) ? ram_rdata : r.rdata;
    assign o_rvalid = (fwft != 0) ? ~r.flags.rempty : r.rvalid;
    assign o_wfull  = r.flags.wfull;
    assign o_afull  = r.flags.afull;
    assign o_rempty = r.flags.rempty;
    assign o_aempty = r.flags.aempty;
    assign o_level  = r.level;

`ifdef SFIFO_EXT_ERR_EN
    logic ovf;
    logic udf;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (i_wr && r.flags.wfull) begin
                ovf <= 1'b1;
            end else if (i_err_clr) begin
                ovf <= 1'b0;
            end
            if (i_rd && r.flags.rempty) begin
                udf <= 1'b1;
            end else if (i_err_clr) begin
                udf <= 1'b0;
            end
        end
    end

    assign o_ovf = ovf;
    assign o_udf = udf;
`endif

endmodule
